// File: rtl/line_write_buffer.sv
// Write-back buffer between the cache line port and line-granular memory.
// Evictions queue in a FIFO; reads hitting a queued line are forwarded.
module line_write_buffer #(
  parameter int LINE_SIZE = 16,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic is_input_valid,
  input  logic mem_read,
  input  logic mem_write,
  input  logic [31:0] addr,
  input  logic [LINE_SIZE*8-1:0] din,
  output logic is_ready,
  output logic is_output_valid,
  output logic [LINE_SIZE*8-1:0] dout,
  output logic m_is_input_valid,
  output logic m_mem_read,
  output logic m_mem_write,
  output logic [31:0] m_addr,
  output logic [LINE_SIZE*8-1:0] m_din,
  input  logic m_is_output_valid,
  input  logic [LINE_SIZE*8-1:0] m_dout,
  input  logic m_mem_ready,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [31:0] fwd_count
);
  localparam int DW = LINE_SIZE * 8;
  localparam int OFF = $clog2(LINE_SIZE);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = 32 - OFF;
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_RESP
  } state_t;

  state_t state;
  logic [TW-1:0] tag [DEPTH];
  logic [DW-1:0] data [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0] head, tail, idx;
  logic [PW-1:0] hit_idx, co_idx;
  logic hit, co_hit, rd_pending;
  logic [TW-1:0] rd_tag, req_tag, pend_tag;
  logic acc, wr, rd, pop, co, push, miss;
  logic [DW-1:0] head_data;
  logic unused_lsb;

  assign unused_lsb = ^addr[OFF-1:0];

  always_comb begin
    req_tag = addr[31:OFF];
    is_ready = reset && !rd_pending &&
      (state == IDLE || state == WR_ISSUE) &&
      (!mem_write || occupancy < FULL);
    acc = is_input_valid && is_ready;
    wr = acc && mem_write;
    rd = acc && mem_read && !mem_write;
    pop = (state == WR_ISSUE) && m_mem_ready;
    hit = 1'b0;
    hit_idx = '0;
    co_hit = 1'b0;
    co_idx = '0;
    idx = '0;
    // Scan oldest to youngest so the last match wins.
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid[idx] && tag[idx] == req_tag) begin
        hit = 1'b1;
        hit_idx = idx;
        if (!(pop && idx == head)) begin
          co_hit = 1'b1;
          co_idx = idx;
        end
      end
    end
    co = wr && co_hit;
    push = wr && !co_hit;
    miss = rd && !hit;
    pend_tag = miss ? req_tag : rd_tag;
    head_data = (co && co_idx == head) ? din : data[head];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      head <= '0;
      tail <= '0;
      valid <= '0;
      occupancy <= '0;
      fwd_count <= '0;
      rd_pending <= 1'b0;
      rd_tag <= '0;
      is_output_valid <= 1'b0;
      dout <= '0;
      m_is_input_valid <= 1'b0;
      m_mem_read <= 1'b0;
      m_mem_write <= 1'b0;
      m_addr <= '0;
      m_din <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag[i] <= '0;
        data[i] <= '0;
      end
    end else begin
      is_output_valid <= 1'b0;
      if (co) data[co_idx] <= din;
      if (push) begin
        tag[tail] <= req_tag;
        data[tail] <= din;
        valid[tail] <= 1'b1;
        tail <= tail + 1'b1;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head <= head + 1'b1;
      end
      if (push && !pop) occupancy <= occupancy + 1'b1;
      else if (pop && !push) occupancy <= occupancy - 1'b1;
      if (rd && hit) begin
        is_output_valid <= 1'b1;
        dout <= data[hit_idx];
        fwd_count <= fwd_count + 32'd1;
      end
      unique case (state)
        IDLE: begin
          if (miss) begin
            state <= RD_ISSUE;
            rd_tag <= req_tag;
            m_is_input_valid <= 1'b1;
            m_mem_read <= 1'b1;
            m_addr <= {req_tag, {OFF{1'b0}}};
          end else if (occupancy != '0 && !rd) begin
            state <= WR_ISSUE;
            m_is_input_valid <= 1'b1;
            m_mem_write <= 1'b1;
            m_addr <= {tag[head], {OFF{1'b0}}};
            m_din <= head_data;
          end
        end
        WR_ISSUE: begin
          if (pop) begin
            m_mem_write <= 1'b0;
            m_din <= '0;
            if (rd_pending || miss) begin
              state <= RD_ISSUE;
              rd_pending <= 1'b0;
              rd_tag <= pend_tag;
              m_mem_read <= 1'b1;
              m_addr <= {pend_tag, {OFF{1'b0}}};
            end else begin
              state <= IDLE;
              m_is_input_valid <= 1'b0;
              m_addr <= '0;
            end
          end else begin
            m_din <= head_data;
            if (miss) begin
              rd_pending <= 1'b1;
              rd_tag <= req_tag;
            end
          end
        end
        RD_ISSUE: begin
          if (m_mem_ready) begin
            state <= RD_WAIT;
            m_is_input_valid <= 1'b0;
            m_mem_read <= 1'b0;
            m_addr <= '0;
          end
        end
        RD_WAIT: begin
          if (m_is_output_valid) begin
            state <= RD_RESP;
            dout <= m_dout;
            is_output_valid <= 1'b1;
          end
        end
        RD_RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
